// File: rtl/lab2_proc_int_mul_iter.sv
// Iterative shift-add multiplier for the X stage: one partial product per cycle.
// Define LAB2_PROC_IMUL_ZERO_SKIP_EN to end early once the remaining b is zero.
module lab2_proc_int_mul_iter #(
    parameter int p_nbits = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reqstream_val,
    output logic                   reqstream_rdy,
    input  logic [2*p_nbits-1:0]   reqstream_msg,
    output logic                   respstream_val,
    input  logic                   respstream_rdy,
    output logic [p_nbits-1:0]     respstream_msg
);

    localparam int CW = $clog2(p_nbits + 1);
    localparam logic [CW-1:0] LAST = CW'(p_nbits - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [p_nbits-1:0]   a_q, a_d;
    logic [p_nbits-1:0]   b_q, b_d;
    logic [p_nbits-1:0]   res_q, res_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 upd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        res_d          = res_q;
        cnt_d          = cnt_q;
        upd            = 1'b0;
        reqstream_rdy  = 1'b0;
        respstream_val = 1'b0;

        unique case (state_q)
            IDLE: begin
                reqstream_rdy = ~reset;
                if (reqstream_val && reqstream_rdy) begin
                    a_d     = reqstream_msg[2*p_nbits-1:p_nbits];
                    b_d     = reqstream_msg[p_nbits-1:0];
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                upd = 1'b1;
`ifdef LAB2_PROC_IMUL_ZERO_SKIP_EN
                // No bits of b left: the result is already final
                if (b_q == '0) begin
                    upd     = 1'b0;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                respstream_val = 1'b1;
                if (respstream_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (upd) begin
            if (b_q[0]) begin
                res_d = res_q + a_q;
            end
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                state_d = DONE;
            end
        end
    end

    assign respstream_msg = res_q;

endmodule
